iir_sample_ram_writer: RTL and testbench
========================================

// Module: iir_sample_ram_writer
// PURPOSE
//   Capture engine between the IIR filter output stream and the 1024x32
//   single-port on-chip sample RAM. Accepts 16-bit filtered samples over a
//   valid/ready handshake. Packs sample pairs into 32-bit words and writes
//   them as a circular buffer through the RAM's Avalon-MM slave port. There
//   is no waitrequest on that port. Signals completion so the CPU can read
//   the captured block.
// PARAMETERS
//   ADDR_W    10    RAM word-address width (depth = 2**ADDR_W)
//   SAMPLE_W  16    sample width; fixed at 16 (two samples per 32-bit word)
// PORTS
//   clk             in   1         system clock
//   reset           in   1         asynchronous, active-high reset
//   start           in   1         one-cycle pulse; arms a capture (ignored unless IDLE)
//   start_addr      in   ADDR_W    first RAM word address, latched on start
//   num_samples     in   ADDR_W+2  sample count, latched on start; legal 0..2*2**ADDR_W
//   in_data         in   16        filtered sample
//   in_valid        in   1         in_data valid
//   in_ready        out  1         engine accepts in_data this cycle
//   ram_address     out  ADDR_W    RAM word address
//   ram_byteenable  out  4         byte lanes written
//   ram_chipselect  out  1         RAM select; asserted only with ram_write
//   ram_write       out  1         RAM write strobe
//   ram_writedata   out  32        {high sample, low sample}
//   busy            out  1         1 in CAPTURE or FLUSH
//   done            out  1         one-cycle completion pulse
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, internal counters and holding register cleared.
//   States: IDLE, CAPTURE, FLUSH, DONE.
//     IDLE    -> CAPTURE when start and num_samples != 0.
//     IDLE    -> DONE when start and num_samples == 0. No RAM write occurs.
//     CAPTURE -> FLUSH when the accepted sample is the last one and the count is odd.
//     CAPTURE -> DONE when the accepted sample is the last one and the count is even.
//     FLUSH   -> DONE after one cycle.
//     DONE    -> IDLE after one cycle; done = 1 only in DONE.
//   in_ready = 1 only in CAPTURE and only while samples remain. Transfer = in_valid & in_ready.
//   Packing: samples are numbered from 0 within the capture.
//     Even-numbered sample: stored in the low holding register; no write.
//     Odd-numbered sample: registered write on the next cycle.
//       ram_writedata = {sample, held low}, ram_byteenable = 4'b1111.
//   Odd total count: the FLUSH cycle writes the final held sample.
//     ram_writedata = {16'h0, held}, ram_byteenable = 4'b0011.
//   Latency: a completing transfer at cycle t produces ram_write = ram_chipselect = 1 at t+1.
//     The state entered at t+1 (DONE or FLUSH) coincides with that final pair write.
//     For even counts, done is asserted in the same cycle as the final write.
//   ram_write is a single-cycle strobe per word. ram_address, ram_writedata and
//     ram_byteenable are held until the next write; they are don't-care otherwise.
//   Address: the first write goes to start_addr. Each write increments the address
//     modulo 2**ADDR_W, so 2**ADDR_W-1 wraps to 0.
//   Bubbles: in_valid gaps stall the capture with no writes and no timeout.
//   start while busy or in DONE: ignored; latched parameters are unchanged.
//   num_samples above 2*2**ADDR_W: clamped to 2*2**ADDR_W.
//   reset mid-capture: the engine aborts immediately.
//     No further writes, no done pulse. A pending half-word is discarded.
//   Counter widths: the sample counter is ADDR_W+2 bits wide. No overflow at the maximum count.
// TESTING
//   1 start_addr=0, num=4, samples 1,2,3,4 back-to-back
//       -> write @0 32'h0002_0001 be=F, then @1 32'h0004_0003 be=F.
//       -> done is high in the same cycle as the @1 write.
//   2 start_addr=5, num=3, samples A,B,C
//       -> write @5 {B,A} be=F, then @6 {0,C} be=3 in FLUSH.
//       -> done pulses the cycle after the @6 write.
//   3 start_addr=1023, num=4 -> writes at 1023 then 0 (wrap); address 1 is untouched.
//   4 num=0 -> done pulses 1 cycle after start; ram_write and in_ready stay 0.
//   5 in_valid toggled 1,0,0,1 with num=2 -> exactly one write, 1 cycle after the second transfer.
//       -> start pulsed mid-capture is ignored.
//   6 reset asserted after the 3rd of 8 samples -> outputs 0 at once; no write; no done.
//       -> a new start then captures correctly from its own start_addr.

Source files
------------

// File: rtl/iir_sample_ram_writer.sv
// iir_sample_ram_writer
//   Capture engine between the IIR filter output stream and a single-port
//   on-chip sample RAM. Accepts 16-bit samples over a valid/ready handshake,
//   packs pairs into 32-bit words {high, low} and writes them as a circular
//   buffer through an Avalon-MM slave port that has no waitrequest. A
//   one-cycle done pulse marks the end of a capture.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start             one-cycle pulse, arms a capture (only honoured in IDLE)
//   start_addr        first RAM word address, latched on start
//   num_samples       sample count, latched on start, clamped to 2*2**ADDR_W
//   in_data/in_valid  sample stream from the filter
//   in_ready          engine accepts in_data this cycle
//   ram_*             Avalon-MM write port (chipselect mirrors write)
//   busy              high while capturing or flushing a trailing half-word
//   done              one-cycle completion pulse
module iir_sample_ram_writer #(
   parameter int ADDR_W   = 10,
   parameter int SAMPLE_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   start_addr,
   input  logic [ADDR_W+1:0]   num_samples,
   input  logic [SAMPLE_W-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [3:0]          ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [31:0]         ram_writedata,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_FLUSH,
      S_DONE
   } state_t;

   // Largest legal count: two samples per RAM word over the full depth.
   localparam logic [ADDR_W+1:0] MAX_CNT = {2'b10, {ADDR_W{1'b0}}};

   state_t              state_q, state_d;
   logic [ADDR_W+1:0]   num_q,   num_d;
   logic [ADDR_W+1:0]   cnt_q,   cnt_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [SAMPLE_W-1:0] held_q,  held_d;
   logic                wr_q,    wr_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          wbe_q,   wbe_d;

   logic [ADDR_W+1:0]   num_clamped;
   logic [ADDR_W+1:0]   cnt_inc;
   logic                ready_c;
   logic                xfer;
   logic                last;

   always_comb begin
      num_clamped = (num_samples > MAX_CNT) ? MAX_CNT : num_samples;
      ready_c     = (state_q == S_CAPTURE) && (cnt_q != num_q);
      xfer        = in_valid & ready_c;
      cnt_inc     = cnt_q + 1'b1;
      last        = (cnt_inc == num_q);
   end

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      held_d  = held_q;
      wr_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wbe_d   = wbe_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_d   = num_clamped;
               cnt_d   = '0;
               addr_d  = start_addr;
               state_d = (num_clamped == '0) ? S_DONE : S_CAPTURE;
            end
         end

         S_CAPTURE: begin
            if (xfer) begin
               cnt_d = cnt_inc;
               if (!cnt_q[0]) begin
                  held_d = in_data;
               end else begin
                  wr_d    = 1'b1;
                  waddr_d = addr_q;
                  wdata_d = {in_data, held_q};
                  wbe_d   = '1;
                  addr_d  = addr_q + 1'b1;
               end

               if (last) begin
                  if (num_q[0]) begin
                     // Odd count: the trailing sample is registered straight
                     // into the write port so the half-word write lands in
                     // the FLUSH cycle itself.
                     wr_d    = 1'b1;
                     waddr_d = addr_q;
                     wdata_d = {16'h0000, in_data};
                     wbe_d   = 4'b0011;
                     addr_d  = addr_q + 1'b1;
                     state_d = S_FLUSH;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
         end

         S_FLUSH: state_d = S_DONE;

         S_DONE:  state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         num_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         held_q  <= '0;
         wr_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         wbe_q   <= '0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         held_q  <= held_d;
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         wbe_q   <= wbe_d;
      end
   end

   assign in_ready       = ready_c;
   assign ram_write      = wr_q;
   assign ram_chipselect = wr_q;
   assign ram_address    = waddr_q;
   assign ram_writedata  = wdata_q;
   assign ram_byteenable = wbe_q;
   assign busy           = (state_q == S_CAPTURE) || (state_q == S_FLUSH);
   assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_iir_sample_ram_writer.sv
// tb_iir_sample_ram_writer
//   Randomised and directed captures against a transaction-level model of
//   the sample RAM writer: every accepted sample is queued, each completed
//   pair becomes one expected word write one cycle later, and an odd tail
//   becomes a half-word write followed by done.
module tb_iir_sample_ram_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  start_addr = '0;
   logic [11:0] num_samples = '0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [9:0]  ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect;
   logic        ram_write;
   logic [31:0] ram_writedata;
   logic        busy;
   logic        done;

   iir_sample_ram_writer #(.ADDR_W(10), .SAMPLE_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .start_addr     (start_addr),
      .num_samples    (num_samples),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      int          cyc;
      logic [9:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   wr_t log_q[$];
   int  cyc       = 0;
   int  start_cyc = 0;
   int  done_cyc  = -1;

   // Model state: capture descriptor plus expectations for the current cycle.
   bit          m_active = 0;
   bit          m_flushing = 0;
   int          m_num = 0;
   int          m_taken = 0;
   int          m_addr = 0;
   logic [15:0] m_samp[$];
   bit          e_ready = 0, e_write = 0, e_busy = 0, e_done = 0;
   logic [9:0]  e_addr = '0;
   logic [31:0] e_data = '0;
   logic [3:0]  e_be = '0;

   always @(negedge clk) begin
      bit          n_write, n_done, n_flush;
      logic [15:0] s;
      int          nn;
      cyc++;
      if (reset) begin
         chk("reset_outputs",
             {in_ready, ram_address, ram_byteenable, ram_chipselect, ram_write,
              ram_writedata, busy, done}, 64'd0);
         m_active = 0; m_flushing = 0;
         e_ready = 0; e_write = 0; e_busy = 0; e_done = 0;
      end else begin
         chk("in_ready", in_ready, e_ready);
         chk("ram_write", ram_write, e_write);
         chk("ram_chipselect", ram_chipselect, e_write);
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         if (e_write) begin
            chk("ram_address", ram_address, e_addr);
            chk("ram_writedata", ram_writedata, e_data);
            chk("ram_byteenable", ram_byteenable, e_be);
         end
         if (ram_write) log_q.push_back('{cyc, ram_address, ram_writedata, ram_byteenable});
         if (done) done_cyc = cyc;

         n_write = 0; n_done = 0; n_flush = 0;
         if (m_flushing) n_done = 1;
         if (!e_busy && !e_done && start) begin
            nn = (num_samples > 12'd2048) ? 2048 : int'(num_samples);
            start_cyc = cyc;
            if (nn == 0) n_done = 1;
            else begin
               m_active = 1; m_num = nn; m_taken = 0; m_addr = int'(start_addr);
               m_samp.delete();
            end
         end else if (m_active && in_valid) begin
            s = in_data;
            m_samp.push_back(s);
            m_taken++;
            if (m_taken % 2 == 0) begin
               n_write = 1; e_addr = m_addr[9:0]; e_data = {s, m_samp[m_taken-2]}; e_be = 4'hF;
               m_addr = (m_addr + 1) % 1024;
            end
            if (m_taken == m_num) begin
               m_active = 0;
               if (m_num % 2 == 1) begin
                  n_write = 1; e_addr = m_addr[9:0]; e_data = {16'h0000, s}; e_be = 4'h3;
                  m_addr = (m_addr + 1) % 1024;
                  n_flush = 1;
               end else n_done = 1;
            end
         end
         m_flushing = n_flush;
         e_write = n_write;
         e_done  = n_done;
         e_ready = m_active;
         e_busy  = m_active || n_flush;
      end
   end

   // mode 0: always valid, 1: random gaps, 2: valid pattern 1,0,0,1
   task automatic capture(input int a, input int n, input int mode, input bit midstart,
                          input bit fixed_data, input bit wait_done, input int stop_after);
      int nsend, idx, k, w;
      bit v;
      nsend = (n > 2048) ? 2048 : n;
      if (stop_after >= 0 && stop_after < nsend) nsend = stop_after;
      idx = 0; k = 0;
      log_q.delete();
      done_cyc = -1;
      @(posedge clk); #1;
      start = 1'b1; start_addr = a[9:0]; num_samples = n[11:0]; in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      while (idx < nsend && k < 20000) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = ($urandom_range(0, 2) != 0);
            default: v = (k == 0 || k == 3);
         endcase
         in_valid = v;
         in_data  = fixed_data ? 16'(idx + 1) : 16'($urandom);
         if (midstart && k == 1) begin
            start = 1'b1; start_addr = 10'd500; num_samples = 12'd7;
         end
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
         start = 1'b0;
         k++;
      end
      in_valid = 1'b0;
      if (idx != nsend) chk("send_budget", idx, nsend);
      if (wait_done) begin
         w = 0;
         while (!done && w < 10) begin
            @(negedge clk);
            w++;
         end
         if (!done) chk("done_timeout", done, 1'b1);
         repeat (2) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // 1: even count, back-to-back
      capture(0, 4, 0, 0, 1, 1, -1);
      chk("t1_nwrites", log_q.size(), 2);
      chk("t1_w0", {log_q[0].addr, log_q[0].data, log_q[0].be}, {10'd0, 32'h0002_0001, 4'hF});
      chk("t1_w1", {log_q[1].addr, log_q[1].data, log_q[1].be}, {10'd1, 32'h0004_0003, 4'hF});
      chk("t1_w0_cyc", log_q[0].cyc - start_cyc, 3);
      chk("t1_w1_cyc", log_q[1].cyc - start_cyc, 5);
      chk("t1_done_cyc", done_cyc - start_cyc, 5);

      // 2: odd count, flush half-word
      capture(5, 3, 0, 0, 1, 1, -1);
      chk("t2_nwrites", log_q.size(), 2);
      chk("t2_w0", {log_q[0].addr, log_q[0].data, log_q[0].be}, {10'd5, 32'h0002_0001, 4'hF});
      chk("t2_w1", {log_q[1].addr, log_q[1].data, log_q[1].be}, {10'd6, 32'h0000_0003, 4'h3});
      chk("t2_w1_cyc", log_q[1].cyc - start_cyc, 4);
      chk("t2_done_cyc", done_cyc - start_cyc, 5);

      // 3: address wrap
      capture(1023, 4, 0, 0, 1, 1, -1);
      chk("t3_nwrites", log_q.size(), 2);
      chk("t3_addr0", log_q[0].addr, 10'd1023);
      chk("t3_addr1", log_q[1].addr, 10'd0);

      // 4: zero count
      capture(7, 0, 0, 0, 1, 1, -1);
      chk("t4_nwrites", log_q.size(), 0);
      chk("t4_done_cyc", done_cyc - start_cyc, 1);

      // 5: bubbles plus ignored start mid-capture
      capture(40, 2, 2, 1, 1, 1, -1);
      chk("t5_nwrites", log_q.size(), 1);
      chk("t5_w0", {log_q[0].addr, log_q[0].data}, {10'd40, 32'h0002_0001});
      chk("t5_w0_cyc", log_q[0].cyc - start_cyc, 5);
      chk("t5_done_cyc", done_cyc - start_cyc, 5);

      // 6: reset after the 3rd of 8 samples
      capture(200, 8, 0, 0, 1, 0, 3);
      reset = 1'b1;
      #1;
      chk("t6_outputs_now",
          {in_ready, ram_address, ram_byteenable, ram_chipselect, ram_write,
           ram_writedata, busy, done}, 64'd0);
      log_q.delete();
      done_cyc = -1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("t6_no_writes", log_q.size(), 0);
      chk("t6_no_done", done_cyc, -1);
      capture(300, 4, 0, 0, 1, 1, -1);
      chk("t6_restart_w0", {log_q[0].addr, log_q[0].data}, {10'd300, 32'h0002_0001});
      chk("t6_restart_w1", {log_q[1].addr, log_q[1].data}, {10'd301, 32'h0004_0003});

      // randomised captures with gaps
      for (int i = 0; i < 12; i++) begin
         capture($urandom_range(0, 1023), $urandom_range(0, 37), 1, (i % 3) == 0, 0, 1, -1);
      end

      // oversized count clamps to a full buffer
      capture(1000, 4095, 0, 0, 0, 1, -1);
      chk("clamp_nwrites", log_q.size(), 1024);
      chk("clamp_last_addr", log_q[1023].addr, 10'd999);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
